// File: rtl/fetch_pkg.sv
// Shared definitions for the LEGv8 instruction-fetch stage.
//   HALT_INSN     : encoding of CBZ XZR,#0, which freezes fetch
//   IMEM_AW_DEF   : default instruction ROM word-address width
//   fetch_state_t : fetch control FSM states
package fetch_pkg;

  localparam logic [31:0] HALT_INSN   = 32'hb400001f;
  localparam int          IMEM_AW_DEF = 6;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset      : clock, synchronous active-high reset
//   en              : load instr_in/pc_in and mark the entry live
//   flush           : clear the entry to a bubble (beats en)
//   instr_in, pc_in : instruction and its PC from the fetch side
//   instr, pc, valid: registered IF/ID fields
module if_id_reg #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic [31:0]  instr_in,
  input  logic [N-1:0] pc_in,
  output logic [31:0]  instr,
  output logic [N-1:0] pc,
  output logic         valid
);

  logic [31:0]  instr_q, instr_d;
  logic [N-1:0] pc_q, pc_d;
  logic         valid_q, valid_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = '0;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (en) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the LEGv8 pipeline.
//   clk, reset  : clock, synchronous active-high reset (overrides all inputs)
//   stall_F     : hold PC and IF/ID
//   PCSrc_E     : taken branch from EX; redirect PC and flush IF/ID
//   PCBranch_E  : branch target byte address (low two bits ignored)
//   imem_addr   : ROM word address, PC[IMEM_AW+1:2]
//   imem_q      : ROM data, combinational from imem_addr
//   instr_D, pc_D, valid_D : IF/ID register contents
//   halted      : fetch frozen on the halt instruction
//   fetch_count : number of instructions loaded into IF/ID
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int N       = 64,
  parameter int IMEM_AW = IMEM_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_F,
  input  logic               PCSrc_E,
  input  logic [N-1:0]       PCBranch_E,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_q,
  output logic [31:0]        instr_D,
  output logic [N-1:0]       pc_D,
  output logic               valid_D,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  fetch_state_t state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [31:0]  cnt_q, cnt_d;

  logic halt_detect;
  logic freeze;
  logic if_id_flush;
  logic if_id_en;

  // A live halt word in IF/ID stops fetch on the same edge that enters HALT,
  // so the PC stays one word past the halt word and the halt word itself
  // remains visible in IF/ID. A concurrent redirect squashes it instead.
  assign halt_detect = (state_q == RUN) && valid_D && (instr_D == HALT_INSN) && !PCSrc_E;
  assign freeze      = (state_q == HALT) || halt_detect;
  assign if_id_flush = !freeze && PCSrc_E;
  assign if_id_en    = !freeze && !PCSrc_E && !stall_F;

  always_comb begin
    state_d = state_q;
    if (halt_detect) state_d = HALT;
  end

  always_comb begin
    pc_d = pc_q;
    if (if_id_flush) pc_d = {PCBranch_E[N-1:2], 2'b00};
    else if (if_id_en) pc_d = pc_q + N'(4);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (if_id_en) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg #(.N(N)) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .en       (if_id_en),
    .flush    (if_id_flush),
    .instr_in (imem_q),
    .pc_in    (pc_q),
    .instr    (instr_D),
    .pc       (pc_D),
    .valid    (valid_D)
  );

  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;

endmodule : fetch_stage
